// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA scene sequencer.
package vga_seq_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } seq_state_t;

   localparam logic [1:0] FADE_MAX = 2'd3;
   localparam logic [1:0] FADE_MIN = 2'd0;

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the vblank level into a one-cycle frame event on its rising edge.
// The history register comes out of reset high so that a vblank already
// asserted at reset release is not mistaken for a new frame.
module frame_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic vblank,
   output logic frame_evt
);

   logic vblank_q;

   // Previous-cycle vblank, reset high to suppress a spurious first edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vblank_q <= 1'b1;
      else        vblank_q <= vblank;
   end

   assign frame_evt = vblank & ~vblank_q;

endmodule

// File: rtl/vga_scene_sequencer.sv
// Frame-rate controller: per-frame scroll offset plus scene sequencing with
// a four-level fade between scenes. Everything advances only on frame events.
module vga_scene_sequencer
   import vga_seq_pkg::*;
#(
   parameter int OFFSET_W         = 10,
   parameter int FRAMES_PER_SCENE = 120,
   parameter int NUM_SCENES       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vblank,
   input  logic [2:0]          cfg_speed,
   input  logic                cfg_dir,
   input  logic                cfg_pause,
   input  logic                cfg_auto,
   input  logic [1:0]          cfg_scene_sel,
   output logic [OFFSET_W-1:0] scroll_x,
   output logic [1:0]          scene,
   output logic [1:0]          fade_level,
   output logic                transitioning,
   output logic                frame_tick
);

   localparam int CNT_W = $clog2(FRAMES_PER_SCENE) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SCENE - 1);
   localparam logic [1:0] LAST_SCENE = 2'(NUM_SCENES - 1);

   logic                frame_evt;
   seq_state_t          state;
   logic [CNT_W-1:0]    frame_cnt;
   logic [1:0]          target;
   logic [OFFSET_W-1:0] step;
   logic [1:0]          scene_inc;
   logic                sel_ok;

   frame_edge_detect u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .vblank    (vblank),
      .frame_evt (frame_evt)
   );

   assign step          = {{(OFFSET_W-3){1'b0}}, cfg_speed};
   assign scene_inc     = (scene == LAST_SCENE) ? 2'd0 : scene + 2'd1;
   assign sel_ok        = (int'(cfg_scene_sel) < NUM_SCENES) && (cfg_scene_sel != scene);
   assign transitioning = (state != HOLD);

   // Frame tick is the event delayed one cycle, aligned with output updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_tick <= 1'b0;
      else        frame_tick <= frame_evt;
   end

   // Scroll accumulator: wraps naturally at 2^OFFSET_W, independent of scenes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scroll_x <= '0;
      end else if (frame_evt && !cfg_pause) begin
         scroll_x <= cfg_dir ? scroll_x - step : scroll_x + step;
      end
   end

   // Scene FSM: hold, fade down to black, swap scene, fade back up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HOLD;
         frame_cnt  <= '0;
         target     <= 2'd0;
         scene      <= 2'd0;
         fade_level <= FADE_MAX;
      end else if (frame_evt) begin
         case (state)
            HOLD: begin
               if (cfg_auto) begin
                  if (frame_cnt == CNT_LAST) begin
                     target     <= scene_inc;
                     state      <= FADE_OUT;
                     fade_level <= FADE_MAX - 2'd1;
                     frame_cnt  <= '0;
                  end else begin
                     frame_cnt  <= frame_cnt + 1'b1;
                  end
               end else begin
                  frame_cnt <= '0;
                  if (sel_ok) begin
                     target     <= cfg_scene_sel;
                     state      <= FADE_OUT;
                     fade_level <= FADE_MAX - 2'd1;
                  end
               end
            end
            FADE_OUT: begin
               // The black level is held for one full frame before the swap.
               if (fade_level == FADE_MIN) begin
                  scene      <= target;
                  fade_level <= FADE_MIN + 2'd1;
                  state      <= FADE_IN;
               end else begin
                  fade_level <= fade_level - 2'd1;
               end
            end
            FADE_IN: begin
               fade_level <= fade_level + 2'd1;
               if (fade_level == FADE_MAX - 2'd1) begin
                  state     <= HOLD;
                  frame_cnt <= '0;
               end
            end
            default: begin
               state      <= HOLD;
               fade_level <= FADE_MAX;
               frame_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Scoreboard bench for vga_scene_sequencer: the stimulus side models each
// frame event and queues the expected outputs; a monitor compares them
// when frame_tick appears and checks outputs stay put in between.
module tb_vga_scene_sequencer;

   localparam int OW  = 10;
   localparam int FPS = 4;
   localparam int NS  = 3;
   localparam int MOD = 1 << OW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vblank;
   logic [2:0]    cfg_speed;
   logic          cfg_dir, cfg_pause, cfg_auto;
   logic [1:0]    cfg_scene_sel;
   logic [OW-1:0] scroll_x;
   logic [1:0]    scene, fade_level;
   logic          transitioning, frame_tick;

   vga_scene_sequencer #(.OFFSET_W(OW), .FRAMES_PER_SCENE(FPS), .NUM_SCENES(NS)) dut (
      .clk(clk), .rst_n(rst_n), .vblank(vblank), .cfg_speed(cfg_speed),
      .cfg_dir(cfg_dir), .cfg_pause(cfg_pause), .cfg_auto(cfg_auto),
      .cfg_scene_sel(cfg_scene_sel), .scroll_x(scroll_x), .scene(scene),
      .fade_level(fade_level), .transitioning(transitioning), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int scroll;
      int scn;
      int fade;
      int trans;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   // Reference model: a transition is a 6-step script over frame events.
   int fade_script[6] = '{2, 1, 0, 1, 2, 3};
   int m_scroll, m_scene, m_fade, m_step, m_hold, m_target;
   bit m_in_trans;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_scroll = 0; m_scene = 0; m_fade = 3; m_step = 0; m_hold = 0;
      m_target = 0; m_in_trans = 0;
      last = '{scroll: 0, scn: 0, fade: 3, trans: 0};
      sb.delete();
   endtask

   task automatic model_event(input int sp, input bit d, input bit p, input bit a, input int sel);
      exp_t e;
      if (!p) m_scroll = (((m_scroll + (d ? -sp : sp)) % MOD) + MOD) % MOD;
      if (!m_in_trans) begin
         bit go = 0;
         if (a) begin
            m_hold++;
            if (m_hold == FPS) begin
               go = 1; m_target = (m_scene + 1) % NS;
            end
         end else begin
            m_hold = 0;
            if (sel < NS && sel != m_scene) begin
               go = 1; m_target = sel;
            end
         end
         if (go) begin
            m_in_trans = 1; m_step = 0; m_hold = 0; m_fade = fade_script[0];
         end
      end else begin
         m_step++;
         m_fade = fade_script[m_step];
         if (m_step == 3) m_scene = m_target;
         if (m_step == 5) begin
            m_in_trans = 0; m_hold = 0;
         end
      end
      e = '{scroll: m_scroll, scn: m_scene, fade: m_fade, trans: int'(m_in_trans)};
      sb.push_back(e);
   endtask

   task automatic junk();
      cfg_speed = 3'($urandom); cfg_dir = 1'($urandom); cfg_pause = 1'($urandom);
      cfg_auto = 1'($urandom); cfg_scene_sel = 2'($urandom);
   endtask

   // One frame: rising vblank with the given cfg in the event cycle, then
   // junk cfg for the rest of the high and the low portion.
   task automatic frame(input int sp, input bit d, input bit p, input bit a, input int sel,
                        input int hi, input int lo);
      @(posedge clk); #1;
      cfg_speed = 3'(sp); cfg_dir = d; cfg_pause = p; cfg_auto = a; cfg_scene_sel = 2'(sel);
      vblank = 1'b1;
      model_event(sp, d, p, a, sel);
      for (int i = 1; i < hi; i++) begin
         @(posedge clk); #1; junk();
      end
      @(posedge clk); #1; junk(); vblank = 1'b0;
      for (int i = 1; i < lo; i++) begin
         @(posedge clk); #1; junk();
      end
   endtask

   // Monitor: pop on each tick, otherwise outputs must hold their last value.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (frame_tick) begin
            if (sb.size() == 0) begin
               chk("unexpected_tick", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("scroll_x", int'(scroll_x), e.scroll);
               chk("scene", int'(scene), e.scn);
               chk("fade_level", int'(fade_level), e.fade);
               chk("transitioning", int'(transitioning), e.trans);
               last = e;
            end
         end else begin
            chk("hold_scroll_x", int'(scroll_x), last.scroll);
            chk("hold_scene", int'(scene), last.scn);
            chk("hold_fade", int'(fade_level), last.fade);
            chk("hold_trans", int'(transitioning), last.trans);
         end
      end
   end

   task automatic drain(input string name);
      repeat (4) @(posedge clk);
      #1;
      chk(name, sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; vblank = 1'b1; junk();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scroll", int'(scroll_x), 0);
      chk("rst_scene", int'(scene), 0);
      chk("rst_fade", int'(fade_level), 3);
      chk("rst_trans", int'(transitioning), 0);
      chk("rst_tick", int'(frame_tick), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      // vblank high through reset release must produce no event.
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1; junk();
      end
      vblank = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("no_tick_scroll", int'(scroll_x), 0);

      // Scroll: up, down through wrap, paused.
      for (int i = 0; i < 3; i++) frame(5, 0, 0, 0, 0, 2, 2);
      drain("drain_up");
      chk("scroll_15", int'(scroll_x), 15);
      for (int i = 0; i < 4; i++) frame(5, 1, 0, 0, 0, 1, 3);
      for (int i = 0; i < 2; i++) frame(7, 0, 1, 0, 0, 3, 1);
      drain("drain_scroll");
      chk("scroll_wrap", int'(scroll_x), 1019);

      // Auto rotation: one full hold plus transition, and a bit more.
      for (int i = 0; i < 12; i++) frame(1, 0, 0, 1, 0, 1, 2);
      drain("drain_auto");
      chk("auto_scene", int'(scene), 1);

      // Manual: go to 2, change sel mid-fade (ignored), then follow to 0.
      frame(0, 0, 0, 0, 2, 1, 1);
      for (int i = 0; i < 5; i++) frame(0, 0, 0, 1, 0, 1, 1);
      frame(0, 0, 0, 0, 2, 1, 1);
      drain("drain_man1");
      chk("manual_scene2", int'(scene), 2);
      for (int i = 0; i < 7; i++) frame(0, 0, 0, 0, 0, 1, 1);
      drain("drain_man2");
      chk("manual_scene0", int'(scene), 0);

      // Out-of-range manual selection is ignored.
      for (int i = 0; i < 3; i++) frame(2, 0, 0, 0, 3, 2, 1);
      drain("drain_oor");
      chk("oor_trans", int'(transitioning), 0);
      chk("oor_scene", int'(scene), 0);

      // Reset at black mid-transition.
      for (int i = 0; i < 3; i++) frame(3, 0, 0, 0, 1, 1, 1);
      drain("drain_black");
      chk("pre_rst_fade", int'(fade_level), 0);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("arst_fade", int'(fade_level), 3);
      chk("arst_scene", int'(scene), 0);
      chk("arst_trans", int'(transitioning), 0);
      chk("arst_scroll", int'(scroll_x), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      mon_en = 1'b1;

      // Random frames with random cfg and vblank shapes.
      for (int i = 0; i < 150; i++) begin
         frame($urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) != 0), $urandom_range(0, 3),
               $urandom_range(1, 5), $urandom_range(1, 4));
      end
      drain("drain_random");

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   // Hard stop in case something blocks.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
